// File: rtl/rv_xlen_alu_if.sv
// Issue, bypass and result signals of rv_xlen_alu.
// The master side is decode/writeback; the slave side is the ALU.
interface rv_xlen_alu_if #(parameter int XLEN = 32);
    logic            valid_in;
    logic            ready;
    logic [3:0]      op;
    logic            word_op;
    logic [XLEN-1:0] a_in;
    logic [XLEN-1:0] b_in;
    logic [4:0]      a_idx;
    logic [4:0]      b_idx;
    logic [4:0]      wb_idx;
    logic [XLEN-1:0] wb_val;
    logic [4:0]      rd_in;
    logic            stall;
    logic            flush;
    logic            valid_out;
    logic [4:0]      rd;
    logic [XLEN-1:0] c;

    modport master (
        output valid_in, op, word_op, a_in, b_in, a_idx, b_idx, wb_idx, wb_val, rd_in, stall, flush,
        input  ready, valid_out, rd, c
    );
    modport slave (
        input  valid_in, op, word_op, a_in, b_in, a_idx, b_idx, wb_idx, wb_val, rd_in, stall, flush,
        output ready, valid_out, rd, c
    );
endinterface

// File: rtl/rv_xlen_alu.sv
// RV32I/RV64I integer ALU: registered result, writeback bypass, *W word ops and an
// optional iterative shifter moving SHIFT_STEP bits per cycle.
module rv_xlen_alu #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 0,
    parameter int BYPASS     = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    rv_xlen_alu_if.slave  bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    logic [0:0]      state;
    logic            valid_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] c_q;

    logic [XLEN-1:0] sh_val;
    logic [5:0]      sh_rem;
    logic [3:0]      sh_op;
    logic            sh_wop;
    logic [4:0]      sh_rd;

    logic            wop, accept, is_shift, iter_start;
    logic [XLEN-1:0] a_op, b_op, a_x, b_x, shift_res, res_raw, alu_res, sh_nxt;
    logic [5:0]      shamt, step;

    function automatic logic [XLEN-1:0] fin(input logic w, input logic [XLEN-1:0] x);
        return w ? XLEN'($signed(x[31:0])) : x;
    endfunction

    assign wop       = (XLEN == 64) && bus.word_op;
    assign bus.ready = (state == S_IDLE) && !bus.stall && !bus.flush;
    assign accept    = bus.valid_in && bus.ready;

    assign bus.valid_out = valid_q;
    assign bus.rd        = rd_q;
    assign bus.c         = c_q;

    always_comb begin
        a_op = bus.a_in;
        b_op = bus.b_in;
        if (BYPASS != 0 && bus.wb_idx != 5'd0) begin
            if (bus.a_idx == bus.wb_idx) a_op = bus.wb_val;
            if (bus.b_idx == bus.wb_idx) b_op = bus.wb_val;
        end
        // Word ops run on widened 32-bit operands; SRLW needs zero fill, the rest sign fill.
        a_x = a_op;
        b_x = b_op;
        if (wop) begin
            a_x = (bus.op == OP_SRL) ? XLEN'(a_op[31:0]) : XLEN'($signed(a_op[31:0]));
            b_x = XLEN'($signed(b_op[31:0]));
        end
        shamt      = (XLEN == 32 || wop) ? {1'b0, b_op[4:0]} : b_op[5:0];
        is_shift   = bus.op inside {OP_SLL, OP_SRL, OP_SRA};
        iter_start = (SHIFT_STEP != 0) && is_shift && (shamt != 6'd0);

        case (bus.op)
            OP_SLL:  shift_res = a_x << shamt;
            OP_SRL:  shift_res = a_x >> shamt;
            default: shift_res = XLEN'($signed(a_x) >>> shamt);
        endcase
        // With the iterative shifter only shamt==0 completes here, and that is a pass-through.
        if (SHIFT_STEP != 0) shift_res = a_x;

        case (bus.op)
            OP_ADD:                 res_raw = a_x + b_x;
            OP_SUB:                 res_raw = a_x - b_x;
            OP_SLT:                 res_raw = XLEN'($signed(a_x) < $signed(b_x));
            OP_SLTU:                res_raw = XLEN'(a_x < b_x);
            OP_XOR:                 res_raw = a_x ^ b_x;
            OP_OR:                  res_raw = a_x | b_x;
            OP_AND:                 res_raw = a_x & b_x;
            OP_SLL, OP_SRL, OP_SRA: res_raw = shift_res;
            default:                res_raw = '0;
        endcase
        alu_res = fin(wop, res_raw);
    end

    always_comb begin
        step = (sh_rem > 6'(SHIFT_STEP)) ? 6'(SHIFT_STEP) : sh_rem;
        case (sh_op)
            OP_SLL:  sh_nxt = sh_val << step;
            OP_SRL:  sh_nxt = sh_val >> step;
            default: sh_nxt = XLEN'($signed(sh_val) >>> step);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            rd_q    <= '0;
            c_q     <= '0;
            sh_val  <= '0;
            sh_rem  <= '0;
            sh_op   <= '0;
            sh_wop  <= 1'b0;
            sh_rd   <= '0;
        end else if (bus.flush) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            rd_q    <= '0;
        end else if (!bus.stall) begin
            valid_q <= 1'b0;
            if (state == S_SHIFT) begin
                sh_val <= sh_nxt;
                sh_rem <= sh_rem - step;
                if (sh_rem == step) begin
                    state   <= S_IDLE;
                    valid_q <= 1'b1;
                    c_q     <= fin(sh_wop, sh_nxt);
                    rd_q    <= sh_rd;
                end
            end else if (accept) begin
                if (iter_start) begin
                    state  <= S_SHIFT;
                    sh_val <= a_x;
                    sh_rem <= shamt;
                    sh_op  <= bus.op;
                    sh_wop <= wop;
                    sh_rd  <= bus.rd_in;
                end else begin
                    valid_q <= 1'b1;
                    c_q     <= alu_res;
                    rd_q    <= bus.rd_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_xlen_alu.sv
// Bench for rv_xlen_alu: a 64-bit barrel-shift instance and a 32-bit instance with a
// 4-bit/cycle iterative shifter, each checked against a result scoreboard.
module tb_rv_xlen_alu;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                           XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rv_xlen_alu_if #(.XLEN(64)) b64();
    rv_xlen_alu_if #(.XLEN(32)) b32();

    rv_xlen_alu #(.XLEN(64), .SHIFT_STEP(0), .BYPASS(1)) u64 (.clk(clk), .reset_n(reset_n), .bus(b64.slave));
    rv_xlen_alu #(.XLEN(32), .SHIFT_STEP(4), .BYPASS(1)) u32 (.clk(clk), .reset_n(reset_n), .bus(b32.slave));

    exp_t q64[$], q32[$];
    exp_t e64, e32;
    int   total = 0, passed = 0;
    logic st64_prev = 1'b0, st32_prev = 1'b0;

    logic [3:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model64(input logic [3:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [31:0] r32, a32, b32v;
        int sh;
        a32 = a[31:0];
        b32v = b[31:0];
        if (!w) begin
            sh = int'(b[5:0]);
            case (op)
                ADD: r = a + b;
                SUB: r = a - b;
                SLL: r = a << sh;
                SLT: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                SLTU: r = (a < b) ? 64'd1 : 64'd0;
                XOR: r = a ^ b;
                SRL: r = a >> sh;
                SRA: r = $signed(a) >>> sh;
                OR:  r = a | b;
                AND: r = a & b;
                default: r = 64'd0;
            endcase
        end else begin
            sh = int'(b[4:0]);
            case (op)
                ADD: r32 = a32 + b32v;
                SUB: r32 = a32 - b32v;
                SLL: r32 = a32 << sh;
                SLT: r32 = ($signed(a32) < $signed(b32v)) ? 32'd1 : 32'd0;
                SLTU: r32 = (a32 < b32v) ? 32'd1 : 32'd0;
                XOR: r32 = a32 ^ b32v;
                SRL: r32 = a32 >> sh;
                SRA: r32 = $signed(a32) >>> sh;
                OR:  r32 = a32 | b32v;
                AND: r32 = a32 & b32v;
                default: r32 = 32'd0;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic iss64(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] ai, input logic [4:0] bi, input logic [4:0] rdv,
                         input logic [63:0] exp);
        int n = 0;
        exp_t e;
        b64.op = op; b64.word_op = w; b64.a_in = a; b64.b_in = b;
        b64.a_idx = ai; b64.b_idx = bi; b64.rd_in = rdv; b64.valid_in = 1'b1;
        @(negedge clk);
        while (b64.ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("u64 issue timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (n < 100) begin e.rd = rdv; e.c = exp; q64.push_back(e); end
        #1 b64.valid_in = 1'b0;
    endtask

    task automatic iss32(input logic [3:0] op, input logic w, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdv, input logic [31:0] exp, input logic acc);
        int n = 0;
        exp_t e;
        b32.op = op; b32.word_op = w; b32.a_in = a; b32.b_in = b;
        b32.a_idx = 5'd0; b32.b_idx = 5'd0; b32.rd_in = rdv; b32.valid_in = 1'b1;
        @(negedge clk);
        while (acc && b32.ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("u32 issue timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (acc && n < 100) begin e.rd = rdv; e.c = 64'(exp); q32.push_back(e); end
        #1 b32.valid_in = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // A valid_out seen after a stalled edge is a held result, not a new one.
    always @(posedge clk) begin
        st64_prev <= b64.stall;
        st32_prev <= b32.stall;
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && b64.valid_out === 1'b1 && !st64_prev) begin
            if (q64.size() == 0) chk("u64 unexpected result", 64'd1, 64'd0);
            else begin
                e64 = q64.pop_front();
                chk("u64 c", b64.c, e64.c);
                chk("u64 rd", 64'(b64.rd), 64'(e64.rd));
            end
        end
        if (reset_n === 1'b1 && b32.valid_out === 1'b1 && !st32_prev) begin
            if (q32.size() == 0) chk("u32 unexpected result", 64'd1, 64'd0);
            else begin
                e32 = q32.pop_front();
                chk("u32 c", 64'(b32.c), e32.c);
                chk("u32 rd", 64'(b32.rd), 64'(e32.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        b64.valid_in = 0; b64.op = 0; b64.word_op = 0; b64.a_in = 0; b64.b_in = 0; b64.a_idx = 0;
        b64.b_idx = 0; b64.wb_idx = 0; b64.wb_val = 0; b64.rd_in = 0; b64.stall = 0; b64.flush = 0;
        b32.valid_in = 0; b32.op = 0; b32.word_op = 0; b32.a_in = 0; b32.b_in = 0; b32.a_idx = 0;
        b32.b_idx = 0; b32.wb_idx = 0; b32.wb_val = 0; b32.rd_in = 0; b32.stall = 0; b32.flush = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset u64 ready", 64'(b64.ready), 64'd1);
        chk("reset u64 valid_out", 64'(b64.valid_out), 64'd0);
        chk("reset u64 rd", 64'(b64.rd), 64'd0);
        chk("reset u64 c", b64.c, 64'd0);
        chk("reset u32 ready", 64'(b32.ready), 64'd1);
        chk("reset u32 valid_out", 64'(b32.valid_out), 64'd0);
        chk("reset u32 c", 64'(b32.c), 64'd0);
        reset_n = 1'b1;
        sync();

        // 64-bit instance: directed corners, bypass, then back-to-back random ops
        iss64(SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 0, 0, 5'd1, 64'hFFFF_FFFF_F800_0000);
        iss64(SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h21, 0, 0, 5'd2, 64'h0000_0000_4000_0000);
        iss64(ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 0, 0, 5'd3, 64'hFFFF_FFFF_8000_0000);
        iss64(SLL, 1'b0, 64'd1, 64'h41, 0, 0, 5'd4, 64'd2);
        iss64(SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        iss64(SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 5'd6, 64'd1);
        iss64(SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 5'd7, 64'd0);
        iss64(ADD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 5'd8, 64'd0);
        iss64(4'd12, 1'b0, 64'h1234, 64'h5678, 0, 0, 5'd9, 64'd0);
        b64.wb_idx = 5'd3; b64.wb_val = 64'd7;
        iss64(ADD, 1'b0, 64'd0, 64'd2, 5'd3, 5'd0, 5'd10, 64'd9);
        b64.wb_idx = 5'd0;
        iss64(ADD, 1'b0, 64'd0, 64'd2, 5'd3, 5'd0, 5'd11, 64'd2);
        b64.wb_idx = 5'd4; b64.wb_val = 64'h10;
        iss64(SUB, 1'b0, 64'd1, 64'd0, 5'd0, 5'd4, 5'd12, 64'hFFFF_FFFF_FFFF_FFF1);
        b64.wb_idx = 5'd0;
        for (int i = 0; i < 20; i++) begin
            rop = 4'($urandom_range(0, 11));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom(), $urandom()};
            rb  = (i % 3 == 0) ? 64'($urandom_range(0, 70)) : {$urandom(), $urandom()};
            iss64(rop, rw, ra, rb, 5'd0, 5'd0, 5'(i + 1), model64(rop, rw, ra, rb));
        end
        repeat (3) @(negedge clk);
        chk("u64 scoreboard drained", 64'(q64.size()), 64'd0);
        sync();

        // 32-bit instance: wrap, iterative shifts, stall, flush, reset mid-shift
        iss32(ADD, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, 1'b1);
        @(negedge clk);
        chk("add latency valid_out", 64'(b32.valid_out), 64'd1);
        @(negedge clk);
        chk("idle valid_out", 64'(b32.valid_out), 64'd0);
        chk("idle rd hold", 64'(b32.rd), 64'd5);
        sync();

        iss32(SLL, 1'b0, 32'd1, 32'd10, 5'd6, 32'h400, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("sll10 ready low", 64'(b32.ready), 64'd0);
            chk("sll10 no early valid", 64'(b32.valid_out), 64'd0);
        end
        @(negedge clk);
        chk("sll10 valid at cycle 4", 64'(b32.valid_out), 64'd1);
        chk("sll10 ready back", 64'(b32.ready), 64'd1);
        sync();

        iss32(SRA, 1'b1, 32'h8000_0000, 32'h24, 5'd7, 32'hF800_0000, 1'b1);
        iss32(SRL, 1'b0, 32'h8000_0000, 32'd31, 5'd8, 32'd1, 1'b1);

        iss32(SLL, 1'b0, 32'd3, 32'd5, 5'd9, 32'h60, 1'b1);
        sync();
        b32.stall = 1'b1;
        @(negedge clk);
        chk("stall forces ready low", 64'(b32.ready), 64'd0);
        chk("stalled shift no valid c2", 64'(b32.valid_out), 64'd0);
        sync();
        @(negedge clk);
        chk("stalled shift no valid c3", 64'(b32.valid_out), 64'd0);
        sync();
        b32.stall = 1'b0;
        @(negedge clk);
        chk("stalled shift no valid c4", 64'(b32.valid_out), 64'd0);
        @(negedge clk);
        chk("stalled shift valid c5", 64'(b32.valid_out), 64'd1);
        sync();

        iss32(XOR, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd10, 32'hFF00_FF00, 1'b1);
        b32.stall = 1'b1;
        sync();
        @(negedge clk);
        chk("stall holds valid_out", 64'(b32.valid_out), 64'd1);
        chk("stall holds c", 64'(b32.c), 64'hFF00_FF00);
        sync();
        b32.stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post-stall idle valid_out", 64'(b32.valid_out), 64'd0);
        chk("post-stall c hold", 64'(b32.c), 64'hFF00_FF00);
        sync();

        iss32(SRL, 1'b0, 32'h1234, 32'h20, 5'd11, 32'h1234, 1'b1);
        @(negedge clk);
        chk("shamt0 latency 1", 64'(b32.valid_out), 64'd1);
        sync();

        iss32(SLL, 1'b0, 32'd1, 32'd12, 5'd12, 32'h1000, 1'b1);
        sync();
        b32.flush = 1'b1;
        void'(q32.pop_back());
        sync();
        b32.flush = 1'b0;
        @(negedge clk);
        chk("flush valid_out", 64'(b32.valid_out), 64'd0);
        chk("flush ready", 64'(b32.ready), 64'd1);
        chk("flush rd", 64'(b32.rd), 64'd0);
        chk("flush c hold", 64'(b32.c), 64'h1234);
        repeat (4) @(negedge clk);
        sync();
        b32.flush = 1'b1;
        iss32(ADD, 1'b0, 32'd1, 32'd1, 5'd13, 32'd2, 1'b0);
        b32.flush = 1'b0;
        @(negedge clk);
        chk("op with flush rejected", 64'(b32.valid_out), 64'd0);
        sync();

        iss32(SLL, 1'b0, 32'd1, 32'd12, 5'd14, 32'h1000, 1'b1);
        sync();
        reset_n = 1'b0;
        void'(q32.pop_back());
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("reset mid-shift ready", 64'(b32.ready), 64'd1);
        chk("reset mid-shift valid_out", 64'(b32.valid_out), 64'd0);
        chk("reset mid-shift rd", 64'(b32.rd), 64'd0);
        repeat (6) @(negedge clk);
        chk("u32 scoreboard drained", 64'(q32.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
